sprite_compositor: RTL and testbench

- Parametrised, pipelined N-layer sprite compositor. It sits between the per-sprite colour ROM units (player, kong, queue, barrels, ...) and the VGA colour output.
- Selects the highest-priority opaque layer per pixel, falling back to a programmable background colour.
- Adds per-layer enables, a registered 2-stage pipeline with valid tracking, and per-frame player-vs-layer collision flags.

---
 rtl/sprite_compositor_pkg.sv | 34 +++
 rtl/sprite_compositor_if.sv | 34 +++
 rtl/sprite_priority_enc.sv | 22 ++
 rtl/sprite_compositor.sv | 134 +++++++++++++
 tb/tb_sprite_compositor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_compositor_pkg.sv
// rtl/sprite_compositor_pkg.sv - shared constants, layer names and lowest-layer select function
package sprite_compositor_pkg;

    localparam int COLOR_W    = 12;
    localparam int MAX_LAYERS = 16;

    localparam logic [15:0] TRANSP_KEY_DEFAULT = 16'hFFFF;

    // Named layer slots; layer 0 is both highest priority and the collision anchor
    localparam int LAYER_MARIO  = 0;
    localparam int LAYER_QUEUE  = 1;
    localparam int LAYER_KONG   = 2;
    localparam int LAYER_BARREL = 3;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } layer_sel_t;

    // Lowest set bit of the mask wins; scanning downwards leaves the lowest index last
    function automatic layer_sel_t lowest_layer(input logic [MAX_LAYERS-1:0] mask);
        layer_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = 4'd0;
        for (int k = MAX_LAYERS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                sel.found = 1'b1;
                sel.idx   = 4'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel stream in, composited colour and collision flags out
interface sprite_compositor_if
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_W      = 16
) ();

    localparam int IDX_W = $clog2(NUM_LAYERS);

    logic                          pix_valid;
    logic                          frame_start;
    logic [NUM_LAYERS*PIX_W-1:0]   layer_px;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [COLOR_W-1:0]            bg_color;
    logic [COLOR_W-1:0]            color_out;
    logic                          color_valid;
    logic                          hit_any;
    logic [IDX_W-1:0]              hit_layer;
    logic [NUM_LAYERS-1:0]         collide_frame;

    // Pixel source / colour consumer side
    modport master (
        output pix_valid, frame_start, layer_px, layer_en, bg_color,
        input  color_out, color_valid, hit_any, hit_layer, collide_frame
    );

    // Compositor side
    modport slave (
        input  pix_valid, frame_start, layer_px, layer_en, bg_color,
        output color_out, color_valid, hit_any, hit_layer, collide_frame
    );

endinterface

// File: rtl/sprite_priority_enc.sv
// rtl/sprite_priority_enc.sv - combinational lowest-index opaque layer encoder
module sprite_priority_enc
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] opaque_i,
    output logic                  found_o,
    output logic [IDX_W-1:0]      index_o
);

    layer_sel_t sel;

    // Widen the mask to the package function's fixed width; index is 0 when nothing is opaque
    always_comb begin
        sel     = lowest_layer(MAX_LAYERS'(opaque_i));
        found_o = sel.found;
        index_o = IDX_W'(sel.idx);
    end

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - two-stage N-layer sprite compositor with per-frame collision flags
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int               NUM_LAYERS = 4,
    parameter int               PIX_W      = 16,
    parameter logic [PIX_W-1:0] TRANSP_KEY = PIX_W'(TRANSP_KEY_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_compositor_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_LAYERS);
    localparam int LOW_W = PIX_W - COLOR_W;

    // Stage 1 registers
    logic                                s1_valid_q;
    logic [NUM_LAYERS-1:0]               s1_opaque_q;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0]  s1_color_q;
    logic [COLOR_W-1:0]                  s1_bg_q;
    logic                                s1_fs_q;

    // Stage 2 registers and next-state
    logic [COLOR_W-1:0]    color_q,     color_d;
    logic                  valid_q,     valid_d;
    logic                  hit_any_q,   hit_any_d;
    logic [IDX_W-1:0]      hit_layer_q, hit_layer_d;
    logic [NUM_LAYERS-1:0] sticky_q,    sticky_d;
    logic [NUM_LAYERS-1:0] collide_q,   collide_d;

    logic [NUM_LAYERS-1:0]               opaque_in;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0]  color_in;
    logic [NUM_LAYERS*LOW_W-1:0]         px_low_unused;
    logic                                low_bits_unused;
    logic [NUM_LAYERS-1:0]               coll_terms;
    logic                                win_found;
    logic [IDX_W-1:0]                    win_idx;

    // Split each incoming layer word into its opaque flag and colour field
    always_comb begin
        opaque_in     = '0;
        color_in      = '0;
        px_low_unused = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            opaque_in[k] = bus.layer_en[k] && (bus.layer_px[k*PIX_W +: PIX_W] != TRANSP_KEY);
            color_in[k]  = bus.layer_px[k*PIX_W + LOW_W +: COLOR_W];
            px_low_unused[k*LOW_W +: LOW_W] = bus.layer_px[k*PIX_W +: LOW_W];
        end
    end

    assign low_bits_unused = ^px_low_unused;

    // Stage 1 capture: valid follows pix_valid, payload only loads on a valid pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opaque_q <= '0;
            s1_color_q  <= '0;
            s1_bg_q     <= '0;
            s1_fs_q     <= 1'b0;
        end else begin
            s1_valid_q <= bus.pix_valid;
            if (bus.pix_valid) begin
                s1_opaque_q <= opaque_in;
                s1_color_q  <= color_in;
                s1_bg_q     <= bus.bg_color;
                s1_fs_q     <= bus.frame_start;
            end
        end
    end

    sprite_priority_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_prio (
        .opaque_i (s1_opaque_q),
        .found_o  (win_found),
        .index_o  (win_idx)
    );

    // Stage 2 next-state: colour select, hit flags and frame-bounded collision accumulation
    always_comb begin
        color_d     = color_q;
        valid_d     = 1'b0;
        hit_any_d   = hit_any_q;
        hit_layer_d = hit_layer_q;
        sticky_d    = sticky_q;
        collide_d   = collide_q;

        coll_terms              = s1_opaque_q & {NUM_LAYERS{s1_opaque_q[LAYER_MARIO]}};
        coll_terms[LAYER_MARIO] = 1'b0;

        if (s1_valid_q) begin
            valid_d     = 1'b1;
            hit_any_d   = win_found;
            hit_layer_d = win_idx;
            color_d     = win_found ? s1_color_q[win_idx] : s1_bg_q;
            if (s1_fs_q) begin
                // The frame_start pixel opens the new frame, so it does not feed the closing flags
                collide_d = sticky_q;
                sticky_d  = coll_terms;
            end else begin
                sticky_d  = sticky_q | coll_terms;
            end
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q     <= '0;
            valid_q     <= 1'b0;
            hit_any_q   <= 1'b0;
            hit_layer_q <= '0;
            sticky_q    <= '0;
            collide_q   <= '0;
        end else begin
            color_q     <= color_d;
            valid_q     <= valid_d;
            hit_any_q   <= hit_any_d;
            hit_layer_q <= hit_layer_d;
            sticky_q    <= sticky_d;
            collide_q   <= collide_d;
        end
    end

    assign bus.color_out     = color_q;
    assign bus.color_valid   = valid_q;
    assign bus.hit_any       = hit_any_q;
    assign bus.hit_layer     = hit_layer_q;
    assign bus.collide_frame = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed and randomized checks of sprite_compositor against a frame-level model
module tb_sprite_compositor;
    import sprite_compositor_pkg::*;

    localparam int NL = 4;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_LAYERS(NL), .PIX_W(PW)) bus ();

    sprite_compositor #(
        .NUM_LAYERS (NL),
        .PIX_W      (PW),
        .TRANSP_KEY (16'hFFFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [11:0] color;
        logic        hit_any;
        logic [1:0]  layer;
        logic [3:0]  collide;
    } exp_t;

    exp_t       pipe [2];
    exp_t       last;
    logic [3:0] frame_set;
    int         vectors     = 0;
    int         miscompares = 0;

    function automatic logic [NL*PW-1:0] mk(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        last      = '{valid: 1'b0, color: 12'h000, hit_any: 1'b0, layer: 2'd0, collide: 4'd0};
        frame_set = 4'd0;
        pipe[0]   = last;
        pipe[1]   = last;
    endtask

    // What the outputs must show once this input has travelled through the pipe
    task automatic model_step(input logic v, input logic fs, input logic [NL*PW-1:0] px,
                              input logic [NL-1:0] en, input logic [11:0] bg, output exp_t e);
        logic       found;
        logic [3:0] terms;
        logic [NL-1:0] op;
        e       = last;
        e.valid = 1'b0;
        if (v) begin
            found = 1'b0;
            for (int k = 0; k < NL; k++) begin
                op[k] = en[k] && (px[k*PW +: PW] != 16'hFFFF);
                if (!found && op[k]) begin
                    found   = 1'b1;
                    e.color = px[k*PW + 4 +: 12];
                    e.layer = 2'(k);
                end
            end
            if (!found) begin
                e.color = bg;
                e.layer = 2'd0;
            end
            e.hit_any = found;
            e.valid   = 1'b1;
            terms     = 4'd0;
            for (int k = 1; k < NL; k++) terms[k] = op[LAYER_MARIO] && op[k];
            if (fs) begin
                e.collide = frame_set;
                frame_set = terms;
            end else begin
                frame_set = frame_set | terms;
            end
            last = e;
        end
    endtask

    task automatic compare(input exp_t e);
        check("color_valid",   32'(bus.color_valid),   32'(e.valid));
        check("color_out",     32'(bus.color_out),     32'(e.color));
        check("hit_any",       32'(bus.hit_any),       32'(e.hit_any));
        check("hit_layer",     32'(bus.hit_layer),     32'(e.layer));
        check("collide_frame", 32'(bus.collide_frame), 32'(e.collide));
    endtask

    // Present one input cycle, then check the outputs belonging to the input from two cycles back
    task automatic drive(input logic v, input logic fs, input logic [NL*PW-1:0] px,
                         input logic [NL-1:0] en, input logic [11:0] bg);
        exp_t e;
        bus.pix_valid   = v;
        bus.frame_start = fs;
        bus.layer_px    = px;
        bus.layer_en    = en;
        bus.bg_color    = bg;
        model_step(v, fs, px, en, bg, e);
        pipe[1] = pipe[0];
        pipe[0] = e;
        @(posedge clk);
        #1;
        compare(pipe[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {NL*PW{1'b1}}, 4'hF, 12'h00F);
    endtask

    logic [NL*PW-1:0] T;
    logic [NL*PW-1:0] rpx;
    logic [15:0]      w [NL];

    initial begin
        T = {NL*PW{1'b1}};
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_px    = T;
        bus.layer_en    = 4'hF;
        bus.bg_color    = 12'h000;
        rst_n = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_color_out",   32'(bus.color_out),     32'h000);
        check("rst_color_valid", 32'(bus.color_valid),   32'h0);
        check("rst_hit_any",     32'(bus.hit_any),       32'h0);
        check("rst_collide",     32'(bus.collide_frame), 32'h0);
        rst_n = 1'b1;

        // All layers transparent: background shows through
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, T, 4'hF, 12'h00F);
        check("bg_color_out", 32'(bus.color_out), 32'h00F);
        check("bg_hit_any",   32'(bus.hit_any),   32'h0);
        idle(2);

        // Priority and enable change on consecutive pixels
        drive(1'b1, 1'b0, mk(16'hFFFF, 16'hABC0, 16'h1230, 16'hFFFF), 4'hF, 12'h00F);
        drive(1'b1, 1'b0, mk(16'hFFFF, 16'hABC0, 16'h1230, 16'hFFFF), 4'b1101, 12'h00F);
        check("prio_l1_color", 32'(bus.color_out), 32'hABC);
        check("prio_l1_layer", 32'(bus.hit_layer), 32'd1);
        idle(1);
        check("en_off_color", 32'(bus.color_out), 32'h123);
        check("en_off_layer", 32'(bus.hit_layer), 32'd2);

        // Bubble pattern 1,0,1,1,0
        drive(1'b1, 1'b0, mk(16'h1110, T[15:0], T[15:0], T[15:0]), 4'hF, 12'h0F0);
        idle(1);
        drive(1'b1, 1'b0, mk(16'hFFFF, 16'h2220, 16'hFFFF, 16'hFFFF), 4'hF, 12'h0F0);
        drive(1'b1, 1'b0, T, 4'hF, 12'h0F0);
        idle(3);

        // Frame A with a layer0/layer3 overlap, then frame B without any
        drive(1'b1, 1'b1, T, 4'hF, 12'h000);
        drive(1'b1, 1'b0, mk(16'h4440, 16'hFFFF, 16'hFFFF, 16'h5550), 4'hF, 12'h000);
        drive(1'b1, 1'b1, T, 4'hF, 12'h000);
        idle(1);
        check("frame_a_collide", 32'(bus.collide_frame), 32'b1000);
        drive(1'b1, 1'b0, mk(16'hFFFF, 16'h6660, 16'hFFFF, 16'hFFFF), 4'hF, 12'h000);
        drive(1'b1, 1'b1, mk(16'h7770, 16'hFFFF, 16'h8880, 16'hFFFF), 4'hF, 12'h000);
        idle(1);
        check("frame_b_collide", 32'(bus.collide_frame), 32'b0000);
        drive(1'b1, 1'b1, T, 4'hF, 12'h000);
        idle(1);
        check("fs_pixel_counted_next", 32'(bus.collide_frame), 32'b0100);

        // Frame start while pix_valid is low must not close a frame
        drive(1'b0, 1'b1, T, 4'hF, 12'h000);
        idle(3);

        // Reset mid-frame with layers 1 and 2 accumulated
        drive(1'b1, 1'b1, T, 4'hF, 12'h000);
        drive(1'b1, 1'b0, mk(16'h1230, 16'h4560, 16'hFFFF, 16'hFFFF), 4'hF, 12'h000);
        drive(1'b1, 1'b0, mk(16'h1230, 16'hFFFF, 16'h7890, 16'hFFFF), 4'hF, 12'h000);
        drive(1'b1, 1'b0, T, 4'hF, 12'h000);
        rst_n = 1'b0;
        #1;
        check("async_rst_color",   32'(bus.color_out),     32'h000);
        check("async_rst_valid",   32'(bus.color_valid),   32'h0);
        check("async_rst_hit_any", 32'(bus.hit_any),       32'h0);
        check("async_rst_layer",   32'(bus.hit_layer),     32'h0);
        check("async_rst_collide", 32'(bus.collide_frame), 32'h0);
        bus.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        drive(1'b1, 1'b1, T, 4'hF, 12'h000);
        idle(1);
        check("post_rst_collide", 32'(bus.collide_frame), 32'h0);

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NL; k++)
                w[k] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            rpx = mk(w[0], w[1], w[2], w[3]);
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0),
                  rpx,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                  12'($urandom));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
